// File: rtl/spi_mult_master.sv
// SPI master for the serial multiplier peripheral: shifts {a,b} out, waits,
// then shifts the 8-bit product back in and presents it with a done pulse.
module spi_mult_master #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       cs,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  localparam int unsigned PERIOD  = 2 * CLK_DIV;
  localparam int unsigned CNT_MAX = (PERIOD > GAP_CYCLES) ? PERIOD : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] LAST_HALF  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HIGH_START = CNT_W'(CLK_DIV);
  localparam logic [CNT_W-1:0] LAST_PER   = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] LAST_GAP   = CNT_W'(GAP_CYCLES - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEAD = 3'd1;
  localparam logic [2:0] S_TX   = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_RX   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       tx_sr_q, tx_sr_d;
  logic [7:0]       rx_sr_q, rx_sr_d;
  logic [7:0]       result_q, result_d;
  logic             cs_q, cs_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Sequencing plus output decode from next-state values so every pin is a flop.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    tx_sr_d  = tx_sr_q;
    rx_sr_d  = rx_sr_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LEAD;
          cnt_d   = '0;
          bit_d   = '0;
          tx_sr_d = {a, b};
          rx_sr_d = '0;
        end
      end
      S_LEAD: begin
        if (cnt_q == LAST_HALF) begin
          state_d = S_TX;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_TX: begin
        // MOSI advances only at the bit-period boundary (SCLK falling edge).
        if (cnt_q == LAST_PER) begin
          cnt_d   = '0;
          tx_sr_d = {tx_sr_q[6:0], 1'b0};
          if (bit_q == 3'd7) begin
            state_d = S_GAP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == LAST_GAP) begin
          state_d = S_RX;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RX: begin
        // Sample in the last cycle of the SCLK high half.
        if (cnt_q == LAST_PER) begin
          cnt_d   = '0;
          rx_sr_d = {rx_sr_q[6:0], miso};
          if (bit_q == 3'd7) begin
            state_d  = S_DONE;
            result_d = rx_sr_d;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (cnt_q == LAST_HALF) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase

    cs_d   = (state_d == S_IDLE) || (state_d == S_DONE);
    sclk_d = ((state_d == S_TX) || (state_d == S_RX)) && (cnt_d >= HIGH_START);
    mosi_d = ((state_d == S_LEAD) || (state_d == S_TX)) ? tx_sr_d[7] : 1'b0;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE) && (cnt_d == LAST_HALF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      tx_sr_q  <= '0;
      rx_sr_q  <= '0;
      result_q <= '0;
      cs_q     <= 1'b1;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      tx_sr_q  <= tx_sr_d;
      rx_sr_q  <= rx_sr_d;
      result_q <= result_d;
      cs_q     <= cs_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cs     = cs_q;
  assign sclk   = sclk_q;
  assign mosi   = mosi_q;

endmodule

// File: tb/tb_spi_mult_master.sv
// Bench for spi_mult_master: default instance plus a CLK_DIV=2/GAP_CYCLES=1
// instance, each served by a behavioural multiplier peripheral.
module tb_spi_mult_master;

  logic       clk;
  logic       rst_n;
  logic [1:0] start_v;
  logic [3:0] a_v [2];
  logic [3:0] b_v [2];
  logic [1:0] busy_w, done_w, cs_w, sclk_w, mosi_w;
  logic [1:0] miso_w;
  logic [7:0] result_w [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Peripheral model state, one slot per DUT.
  int         cdiv[2]        = '{4, 2};
  int         exp_gap_low[2] = '{20, 3};
  int         rise_cnt[2]    = '{0, 0};
  int         last_rises[2]  = '{0, 0};
  int         hi_len[2]      = '{0, 0};
  int         low_run[2]     = '{0, 0};
  int         gap_low[2]     = '{0, 0};
  int         bad_hi[2]      = '{0, 0};
  int         idle_act[2]    = '{0, 0};
  logic       sclk_prev[2]   = '{1'b0, 1'b0};
  logic [7:0] mosi_bits[2]   = '{8'h00, 8'h00};
  logic [7:0] prod[2]        = '{8'h00, 8'h00};

  spi_mult_master u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
    .busy(busy_w[0]), .done(done_w[0]), .result(result_w[0]),
    .cs(cs_w[0]), .sclk(sclk_w[0]), .mosi(mosi_w[0]), .miso(miso_w[0])
  );

  spi_mult_master #(.CLK_DIV(2), .GAP_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
    .busy(busy_w[1]), .done(done_w[1]), .result(result_w[1]),
    .cs(cs_w[1]), .sclk(sclk_w[1]), .mosi(mosi_w[1]), .miso(miso_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Peripheral: capture 8 MOSI bits on SCLK rises, answer with the product.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (cs_w[i]) begin
        if (sclk_w[i]) idle_act[i]++;
        if (rise_cnt[i] != 0) last_rises[i] = rise_cnt[i];
        rise_cnt[i] = 0;
        miso_w[i]   = 1'b0;
        hi_len[i]   = 0;
        low_run[i]  = 0;
      end else if (sclk_w[i]) begin
        if (!sclk_prev[i]) begin
          if (rise_cnt[i] == 8) gap_low[i] = low_run[i];
          if (rise_cnt[i] < 8) begin
            mosi_bits[i] = {mosi_bits[i][6:0], mosi_w[i]};
            if (rise_cnt[i] == 7)
              prod[i] = {4'b0, mosi_bits[i][7:4]} * {4'b0, mosi_bits[i][3:0]};
          end else begin
            miso_w[i] = prod[i][3'(15 - rise_cnt[i])];
          end
          rise_cnt[i]++;
        end
        hi_len[i]++;
        low_run[i] = 0;
      end else begin
        if (sclk_prev[i] && hi_len[i] != cdiv[i]) bad_hi[i]++;
        hi_len[i] = 0;
        low_run[i]++;
      end
      sclk_prev[i] = sclk_w[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Call at a negedge; returns at the negedge of the first idle cycle.
  task automatic run_txn(input int i, input logic [3:0] av, input logic [3:0] bv,
                         input logic [7:0] exp_mosi, input logic [7:0] exp_res,
                         input int exp_total, input bit spurious);
    int         done_n;
    int         done_at;
    int         idle_at;
    logic [7:0] res_at_done;
    done_n = 0; done_at = 0; idle_at = 0; res_at_done = 8'h00;
    bad_hi[i] = 0; idle_act[i] = 0;
    start_v[i] = 1'b1; a_v[i] = av; b_v[i] = bv;
    @(negedge clk);
    start_v[i] = 1'b0; a_v[i] = ~av; b_v[i] = ~bv;
    check("accept_busy", 32'(busy_w[i]), 32'd1);
    check("accept_cs", 32'(cs_w[i]), 32'd0);
    check("accept_mosi", 32'(mosi_w[i]), 32'(av[3]));
    for (int k = 1; k <= exp_total + 20 && idle_at == 0; k++) begin
      if (k > 1) @(negedge clk);
      if (done_w[i]) begin
        done_n++;
        done_at     = k;
        res_at_done = result_w[i];
      end
      if (!busy_w[i]) idle_at = k;
      start_v[i] = spurious && (k == 10 || k == 100);
      if (start_v[i]) begin
        a_v[i] = 4'h1;
        b_v[i] = 4'h1;
      end
    end
    start_v[i] = 1'b0;
    check("done_count", 32'(done_n), 32'd1);
    check("done_cycle", 32'(done_at), 32'(exp_total));
    check("busy_low_cycle", 32'(idle_at), 32'(exp_total + 1));
    check("result_at_done", 32'(res_at_done), 32'(exp_res));
    check("result_held", 32'(result_w[i]), 32'(exp_res));
    check("mosi_bits", 32'(mosi_bits[i]), 32'(exp_mosi));
    check("sclk_rises", 32'(last_rises[i]), 32'd16);
    check("sclk_high_len", 32'(bad_hi[i]), 32'd0);
    check("sclk_while_cs_high", 32'(idle_act[i]), 32'd0);
    check("gap_low_run", 32'(gap_low[i]), 32'(exp_gap_low[i]));
  endtask

  initial begin
    int dn;
    rst_n = 1'b0;
    start_v = 2'b00;
    a_v = '{4'h0, 4'h0};
    b_v = '{4'h0, 4'h0};
    repeat (3) @(negedge clk);
    check("rst_cs", 32'(cs_w[0]), 32'd1);
    check("rst_sclk", 32'(sclk_w[0]), 32'd0);
    check("rst_mosi", 32'(mosi_w[0]), 32'd0);
    check("rst_busy", 32'(busy_w[0]), 32'd0);
    check("rst_done", 32'(done_w[0]), 32'd0);
    check("rst_result", 32'(result_w[0]), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_txn(0, 4'h3, 4'h5, 8'h35, 8'h0F, 152, 1'b0);
    repeat (3) @(negedge clk);
    run_txn(0, 4'hF, 4'hF, 8'hFF, 8'hE1, 152, 1'b0);
    run_txn(0, 4'h0, 4'h9, 8'h09, 8'h00, 152, 1'b0);
    repeat (3) @(negedge clk);
    run_txn(0, 4'hA, 4'h5, 8'hA5, 8'h32, 152, 1'b0);
    repeat (3) @(negedge clk);
    run_txn(0, 4'h2, 4'h7, 8'h27, 8'h0E, 152, 1'b1);
    repeat (20) @(negedge clk);
    check("no_queued_start", 32'(busy_w[0]), 32'd0);

    // Abort in TX with a nonzero result still held from the previous run.
    start_v[0] = 1'b1; a_v[0] = 4'hC; b_v[0] = 4'h3;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (29) @(negedge clk);
    check("pre_rst_busy", 32'(busy_w[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_cs", 32'(cs_w[0]), 32'd1);
    check("midrst_sclk", 32'(sclk_w[0]), 32'd0);
    check("midrst_busy", 32'(busy_w[0]), 32'd0);
    check("midrst_result", 32'(result_w[0]), 32'd0);
    check("midrst_mosi", 32'(mosi_w[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int k = 0; k < 160; k++) begin
      @(negedge clk);
      if (done_w[0]) dn++;
    end
    check("midrst_no_done", 32'(dn), 32'd0);
    check("midrst_idle", 32'(busy_w[0]), 32'd0);
    run_txn(0, 4'h2, 4'h3, 8'h23, 8'h06, 152, 1'b0);

    repeat (3) @(negedge clk);
    run_txn(1, 4'h6, 4'h7, 8'h67, 8'h2A, 69, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
